// File: rtl/ultrasonic_control.sv
// ultrasonic_control: HC-SR04-style range controller; pulses the trigger, times the echo in us ticks.
// Optional echo timeout is compiled in when ULTRASONIC_TIMEOUT_EN is defined.
module ultrasonic_control #(
    parameter int unsigned CLK_DIV       = 100,
    parameter int unsigned TRIG_CYCLES   = 1000,
    parameter int unsigned PERIOD_CYCLES = 6_000_000,
    parameter int unsigned TIMEOUT_US    = 38000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        signal,
    output logic        start,
    output logic [15:0] value
);

    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PER_W   = $clog2(PERIOD_CYCLES);

    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0]   TRIG_LAST   = PER_W'(TRIG_CYCLES - 1);
    localparam logic [PER_W-1:0]   PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
`ifdef ULTRASONIC_TIMEOUT_EN
    localparam logic [15:0]        TIMEOUT_VAL = 16'(TIMEOUT_US);
`endif

    if (CLK_DIV < 1 || TRIG_CYCLES < 1 || PERIOD_CYCLES <= TRIG_CYCLES ||
        TIMEOUT_US < 1 || TIMEOUT_US > 65535) begin : g_bad_params
        $error("ultrasonic_control: inconsistent parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t             r_state;
    logic               r_start;
    logic [15:0]        r_value;
    logic [PER_W-1:0]   r_period_cnt;
    logic [PRESC_W-1:0] r_presc;
    logic [15:0]        r_us_cnt;
    logic               r_sig_meta;
    logic               r_sig_s;
    logic               w_tick;
    logic               w_timing;

    assign start = r_start;
    assign value = r_value;

    // The echo pin is asynchronous to clk; nothing but r_sig_s may be used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_meta <= 1'b0;
            r_sig_s    <= 1'b0;
        end else begin
            r_sig_meta <= signal;
            r_sig_s    <= r_sig_meta;
        end
    end

    assign w_tick   = (r_presc == PRESC_LAST);
    assign w_timing = (r_state == S_WAIT_ECHO) || (r_state == S_MEASURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_value      <= 16'h0000;
            r_period_cnt <= '0;
            r_presc      <= '0;
            r_us_cnt     <= 16'h0000;
        end else begin
            if (r_state != S_IDLE && r_period_cnt != PERIOD_LAST)
                r_period_cnt <= r_period_cnt + PER_W'(1);

            if (w_timing) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (r_us_cnt != 16'hFFFF)
                        r_us_cnt <= r_us_cnt + 16'd1;
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end

            // NOTE: the state decisions below are non-blocking and placed last, so any
            // counter clear they make overrides the free-running updates above.
            if (!enable) begin
                r_state      <= S_IDLE;
                r_start      <= 1'b0;
                r_period_cnt <= '0;
                r_presc      <= '0;
                r_us_cnt     <= 16'h0000;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state      <= S_TRIGGER;
                        r_start      <= 1'b1;
                        r_period_cnt <= '0;
                    end
                    S_TRIGGER: begin
                        if (r_period_cnt == TRIG_LAST) begin
                            r_state  <= S_WAIT_ECHO;
                            r_start  <= 1'b0;
                            r_presc  <= '0;
                            r_us_cnt <= 16'h0000;
                        end
                    end
                    S_WAIT_ECHO: begin
                        if (r_sig_s) begin
                            r_state  <= S_MEASURE;
                            r_presc  <= '0;
                            r_us_cnt <= 16'h0000;
                        end
`ifdef ULTRASONIC_TIMEOUT_EN
                        else if (r_us_cnt == TIMEOUT_VAL) begin
                            r_value <= 16'hFFFF;
                            r_state <= S_HOLDOFF;
                        end
`endif
                    end
                    S_MEASURE: begin
                        if (!r_sig_s) begin
                            r_value <= r_us_cnt;
                            r_state <= S_HOLDOFF;
                        end
`ifdef ULTRASONIC_TIMEOUT_EN
                        else if (r_us_cnt == TIMEOUT_VAL) begin
                            r_value <= 16'hFFFF;
                            r_state <= S_HOLDOFF;
                        end
`endif
                    end
                    S_HOLDOFF: begin
                        // An echo that overran the period arrives here already saturated.
                        if (r_period_cnt == PERIOD_LAST) begin
                            r_state      <= S_TRIGGER;
                            r_start      <= 1'b1;
                            r_period_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_start <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_control.sv
// tb_ultrasonic_control: directed and randomized echo stimulus against a time-based width model.
// Uses scaled timing parameters so every scenario fits in a short run.
`timescale 1ns/1ps
module tb_ultrasonic_control;

    localparam int unsigned CLK_DIV       = 4;
    localparam int unsigned TRIG_CYCLES   = 10;
    localparam int unsigned PERIOD_CYCLES = 600;
    localparam int unsigned TIMEOUT_US    = 3000;
    localparam time         CLK_PERIOD    = 10;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        signal = 1'b0;
    logic        start;
    logic [15:0] value;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_val    = 0;
    time rise_q[$];
    logic start_prev = 1'b0;

    ultrasonic_control #(
        .CLK_DIV      (CLK_DIV),
        .TRIG_CYCLES  (TRIG_CYCLES),
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .TIMEOUT_US   (TIMEOUT_US)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .signal(signal),
        .start (start),
        .value (value)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1 && start_prev !== 1'b1)
            rise_q.push_back($time);
        start_prev <= start;
    end

    initial begin
        #(60_000 * CLK_PERIOD);
        $display("FAIL watchdog: run did not finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Measurement resolution is one tick, so published widths are accepted within +/-1.
    task automatic check_near(input string tag, input logic [15:0] obs, input int exp);
        logic ok;
        ok = !$isunknown(obs) && (int'(obs) >= exp - 1) && (int'(obs) <= exp + 1);
        tests_run++;
        assert (ok === 1'b1) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d+/-1", tag, obs, exp);
        end
    endtask

    function automatic int ideal_us(input time t_r, input time t_w, input time t_f);
        time t_s;
        t_s = (t_r > t_w) ? t_r : t_w;
        return int'((t_f - t_s) / (CLK_PERIOD * CLK_DIV));
    endfunction

    task automatic wait_start_high(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (start !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        ok = (start === 1'b1);
    endtask

    // Waits for a trigger, measures its width, optionally raises the echo mid-trigger.
    task automatic run_trigger(input string tag, input int echo_at, output time t_wait);
        int  n;
        int  width;
        bit  ok;
        wait_start_high(2 * PERIOD_CYCLES, n, ok);
        check_eq({tag, "_trig_seen"}, 32'(ok), 32'd1);
        width = 0;
        while (start === 1'b1 && width <= int'(TRIG_CYCLES) + 4) begin
            width++;
            if (width == echo_at) signal = 1'b1;
            @(negedge clk);
        end
        check_eq({tag, "_trig_width"}, 32'(width), 32'(TRIG_CYCLES));
        t_wait = $time;
    endtask

    task automatic echo_pulse(input int clocks, output time t_r, output time t_f);
        signal = 1'b1;
        t_r = $time;
        repeat (clocks) @(negedge clk);
        signal = 1'b0;
        t_f = $time;
    endtask

    task automatic check_publish(input string tag, input int exp);
        @(negedge clk);
        check_near({tag, "_hold"}, value, model_val);
        repeat (2) @(negedge clk);
        check_near(tag, value, exp);
        model_val = exp;
    endtask

    task automatic check_gap(input string tag, input bit overrun);
        time gap;
        if (rise_q.size() < 2) begin
            check_eq({tag, "_rises"}, 32'(rise_q.size()), 32'd2);
        end else begin
            gap = (rise_q[$] - rise_q[$-1]) / CLK_PERIOD;
            if (overrun) check_eq({tag, "_longer"}, 32'(gap > time'(PERIOD_CYCLES)), 32'd1);
            else         check_eq(tag, 32'(gap), 32'(PERIOD_CYCLES));
        end
    endtask

    initial begin
        time t_w;
        time t_r;
        time t_f;
        int  n;
        int  high_cnt;
        int  w_clk;
        bit  ok;

        // Reset held with enable high: outputs stay cleared.
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("reset_start", 32'(start), 32'd0);
        check_eq("reset_value", 32'(value), 32'd0);

        rst_n = 1'b1;
        wait_start_high(5, n, ok);
        check_eq("first_trig_seen", 32'(ok), 32'd1);
        check_eq("first_trig_latency", 32'(n), 32'd1);

        // Asynchronous reset in the middle of a trigger pulse.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_start", 32'(start), 32'd0);
        check_eq("async_reset_value", 32'(value), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_disabled_start", 32'(start), 32'd0);
        rise_q.delete();

        // Basic cycle: echo rises during the trigger, measurement starts at trigger end.
        enable = 1'b1;
        run_trigger("basic", 2, t_w);
        repeat (91 * CLK_DIV) @(negedge clk);
        signal = 1'b0;
        t_f = $time;
        check_publish("basic", ideal_us(0, t_w, t_f));

        // Randomized echoes after the trigger, each fitting inside one period.
        for (int i = 0; i < 4; i++) begin
            run_trigger($sformatf("rand%0d", i), 0, t_w);
            check_gap($sformatf("rand%0d_gap", i), 1'b0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            w_clk = $urandom_range(5 * CLK_DIV, 110 * CLK_DIV);
            echo_pulse(w_clk, t_r, t_f);
            check_publish($sformatf("rand%0d", i), ideal_us(t_r, t_w, t_f));
        end

        // Disable in the middle of a measurement: nothing partial is published.
        run_trigger("dis", 0, t_w);
        signal = 1'b1;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("dis_start", 32'(start), 32'd0);
        check_near("dis_value_kept", value, model_val);
        repeat (20) @(negedge clk);
        signal = 1'b0;
        repeat (5) @(negedge clk);
        check_near("dis_no_partial", value, model_val);
        high_cnt = 0;
        for (int c = 0; c < int'(PERIOD_CYCLES) + 50; c++) begin
            @(negedge clk);
            if (start !== 1'b0) high_cnt++;
        end
        check_eq("dis_idle_no_trigger", 32'(high_cnt), 32'd0);

        // Re-enable: trigger on the next edge, then back-to-back 100 us and 2000 us echoes.
        enable = 1'b1;
        @(negedge clk);
        check_eq("reenable_latency", 32'(start), 32'd1);
        run_trigger("b2b_a", 0, t_w);
        echo_pulse(100 * CLK_DIV, t_r, t_f);
        check_publish("b2b_100", 100);
        run_trigger("b2b_b", 0, t_w);
        check_gap("b2b_gap", 1'b0);
        echo_pulse(2000 * CLK_DIV, t_r, t_f);
        check_publish("b2b_2000", 2000);
        run_trigger("overrun", 0, t_w);
        check_gap("overrun_gap", 1'b1);

        // No echo after a trigger.
`ifdef ULTRASONIC_TIMEOUT_EN
        n = 0;
        while (value !== 16'hFFFF && n < int'(TIMEOUT_US * CLK_DIV) + 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_value", 32'(value), 32'hFFFF);
        wait_start_high(PERIOD_CYCLES, n, ok);
        check_eq("timeout_next_trig", 32'(ok), 32'd1);
`else
        high_cnt = 0;
        for (int c = 0; c < 3 * int'(PERIOD_CYCLES); c++) begin
            @(negedge clk);
            if (start !== 1'b0) high_cnt++;
        end
        check_eq("noecho_stays_waiting", 32'(high_cnt), 32'd0);
        check_near("noecho_value_kept", value, model_val);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
